// File: rtl/adam_pause_if.sv
// Pause-tree handshake bundle: one upstream req/ack pair plus NO_CHILDREN downstream pairs.
// The slave modport is the sequencer's view; master is whatever surrounds it (upstream master and children).
interface adam_pause_if #(
  parameter int NO_CHILDREN = 4
);
  logic                   pause_req;
  logic                   pause_ack;
  logic [NO_CHILDREN-1:0] child_req;
  logic [NO_CHILDREN-1:0] child_ack;

  modport master (
    output pause_req,
    output child_ack,
    input  pause_ack,
    input  child_req
  );

  modport slave (
    input  pause_req,
    input  child_ack,
    output pause_ack,
    output child_req
  );
endinterface

// File: rtl/adam_pause_sequencer.sv
// Pause-tree node: resumes children in ascending order, pauses them in descending order,
// and reports the upstream ack only after the whole chain has completed its handshakes.
module adam_pause_sequencer #(
  parameter int NO_CHILDREN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  adam_pause_if.slave bus
);

  localparam int IDX_W = (NO_CHILDREN > 1) ? $clog2(NO_CHILDREN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_CHILDREN - 1);

  typedef enum logic [1:0] {
    PAUSED,
    RESUMING,
    RUNNING,
    PAUSING
  } state_t;

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [NO_CHILDREN-1:0] child_req_reg, child_req_next;
  logic                   pause_ack_reg, pause_ack_next;

  logic [NO_CHILDREN-1:0] idx_sel;
  logic                   ack_cur;
  logic [IDX_W-1:0]       idx_inc;
  logic [IDX_W-1:0]       idx_dec;

  // One-hot select of the child currently in flight; acks of all other children are masked off.
  genvar gi;
  generate
    for (gi = 0; gi < NO_CHILDREN; gi++) begin : g_sel
      assign idx_sel[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign ack_cur = |(bus.child_ack & idx_sel);
  assign idx_inc = idx_reg + 1'b1;
  assign idx_dec = idx_reg - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= PAUSED;
      idx_reg       <= '0;
      child_req_reg <= '1;
      pause_ack_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      child_req_reg <= child_req_next;
      pause_ack_reg <= pause_ack_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    child_req_next = child_req_reg;
    pause_ack_next = pause_ack_reg;

    case (state_reg)
      PAUSED: begin
        pause_ack_next = 1'b1;
        if (!bus.pause_req) begin
          state_next        = RESUMING;
          idx_next          = '0;
          child_req_next[0] = 1'b0;
        end
      end

      // The req of child[idx] was already driven on entry, so a matching ack finishes the step.
      RESUMING: begin
        if (!ack_cur) begin
          if (idx_reg != LAST_IDX) begin
            idx_next                = idx_inc;
            child_req_next[idx_inc] = 1'b0;
          end else begin
            state_next     = RUNNING;
            pause_ack_next = 1'b0;
          end
        end
      end

      RUNNING: begin
        pause_ack_next = 1'b0;
        if (bus.pause_req) begin
          state_next               = PAUSING;
          idx_next                 = LAST_IDX;
          child_req_next[LAST_IDX] = 1'b1;
        end
      end

      PAUSING: begin
        if (ack_cur) begin
          if (idx_reg != '0) begin
            idx_next                = idx_dec;
            child_req_next[idx_dec] = 1'b1;
          end else begin
            state_next     = PAUSED;
            pause_ack_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = PAUSED;
      end
    endcase
  end

  assign bus.pause_ack = pause_ack_reg;
  assign bus.child_req = child_req_reg;

endmodule

// File: tb/tb_adam_pause_sequencer.sv
// Directed and randomized checks of the pause sequencer against a timing model derived
// from per-child ack latencies: each child step costs (latency + 1) cycles.
module tb_adam_pause_sequencer;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  int         lat [N];
  bit [N-1:0] stuck_en;
  bit [N-1:0] stuck_val;

  adam_pause_if #(.NO_CHILDREN(N)) bus ();

  adam_pause_sequencer #(.NO_CHILDREN(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Child responders: ack follows req lat[i] negedges after the mismatch appears;
  // stuck_en overrides a child's ack with stuck_val.
  initial begin
    logic [N-1:0] ack_v;
    int           cnt [N];
    ack_v = '1;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    bus.child_ack = ack_v;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (stuck_en[i]) begin
          ack_v[i] = stuck_val[i];
          cnt[i]   = 0;
        end else if (bus.child_req[i] !== ack_v[i]) begin
          if (cnt[i] >= lat[i]) begin
            ack_v[i] = bus.child_req[i];
            cnt[i]   = 0;
          end else begin
            cnt[i]++;
          end
        end else begin
          cnt[i] = 0;
        end
      end
      bus.child_ack = ack_v;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hold(input string tag, input int cycles, input logic [N-1:0] exp_req,
                          input logic exp_ack);
    for (int c = 0; c < cycles; c++) begin
      step();
      chk({tag, "_req"}, 8'(bus.child_req), 8'(exp_req));
      chk({tag, "_ack"}, 8'(bus.pause_ack), 8'(exp_ack));
    end
  endtask

  task automatic rand_lat(input int max_lat);
    for (int i = 0; i < N; i++) lat[i] = $urandom_range(max_lat, 0);
  endtask

  // Drives pause_req to the target and checks every cycle against the latency model.
  // Posedge m=1 samples the request; child k's req flips at off[k], upstream ack at total.
  task automatic run_seq(input string name, input bit to_pause, input int stop_at,
                         input int toggle_at);
    int             off [N];
    int             acc;
    int             total;
    logic [N-1:0]   exp_req;
    logic           exp_ack;
    acc = 1;
    if (!to_pause) begin
      for (int k = 0; k < N; k++) begin
        off[k] = acc;
        acc += lat[k] + 1;
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        off[k] = acc;
        acc += lat[k] + 1;
      end
    end
    total = acc;
    bus.pause_req = to_pause;
    for (int m = 1; m <= total; m++) begin
      step();
      for (int i = 0; i < N; i++) exp_req[i] = (m >= off[i]) ? to_pause : ~to_pause;
      exp_ack = (m >= total) ? to_pause : ~to_pause;
      chk({name, "_child_req"}, 8'(bus.child_req), 8'(exp_req));
      chk({name, "_pause_ack"}, 8'(bus.pause_ack), 8'(exp_ack));
      if (m == toggle_at) bus.pause_req = ~to_pause;
      if (m == stop_at) break;
    end
    $display("%s: to_pause=%0d lat=%0d,%0d,%0d,%0d cycles=%0d", name, to_pause,
             lat[0], lat[1], lat[2], lat[3], total);
  endtask

  initial begin
    int n;
    vectors       = 0;
    miscompares   = 0;
    stuck_en      = '0;
    stuck_val     = '0;
    for (int i = 0; i < N; i++) lat[i] = 0;
    rst_n         = 1'b0;
    bus.pause_req = 1'b1;

    // Reset: paused, all children requested to pause, held while pause_req stays high.
    repeat (3) @(negedge clk);
    chk("reset_req", 8'(bus.child_req), 8'h0f);
    chk("reset_ack", 8'(bus.pause_ack), 8'h01);
    step();
    rst_n = 1'b1;
    chk_hold("post_reset", 4, 4'b1111, 1'b1);
    $display("reset released, holding paused");

    lat[0] = 0; lat[1] = 3; lat[2] = 1; lat[3] = 5;
    run_seq("resume_0315", 1'b0, 0, 0);
    chk_hold("running_hold", 2, 4'b0000, 1'b0);

    for (int i = 0; i < N; i++) lat[i] = 0;
    run_seq("pause_min", 1'b1, 0, 0);
    chk_hold("paused_hold", 2, 4'b1111, 1'b1);

    for (int it = 0; it < 6; it++) begin
      rand_lat(4);
      run_seq("rand_seq", (it % 2) == 1, 0, 0);
      n = $urandom_range(3, 0);
      chk_hold("rand_hold", n, ((it % 2) == 1) ? 4'b1111 : 4'b0000, (it % 2) == 1);
    end

    // Ack glitches on children while running are ignored.
    rand_lat(3);
    run_seq("resume_pre_glitch", 1'b0, 0, 0);
    for (int i = 0; i < N; i++) lat[i] = 0;
    stuck_en  = 4'b1001;
    stuck_val = 4'b1001;
    chk_hold("glitch_run", 3, 4'b0000, 1'b0);
    stuck_en  = '0;
    chk_hold("glitch_clear", 3, 4'b0000, 1'b0);
    $display("glitch on child_ack while running ignored");

    // pause_req drops mid-pause: the pause completes, then a resume starts right after.
    rand_lat(3);
    run_seq("pause_toggled", 1'b1, 0, 2);
    run_seq("resume_after_toggle", 1'b0, 0, 0);

    rand_lat(2);
    run_seq("pause_pre_stuck", 1'b1, 0, 0);

    // Child 1 refuses to resume: sequence parks on idx 1.
    for (int i = 0; i < N; i++) lat[i] = 0;
    stuck_en[1]   = 1'b1;
    stuck_val[1]  = 1'b1;
    bus.pause_req = 1'b0;
    step();
    step();
    chk_hold("stuck_child1", 10, 4'b1100, 1'b1);
    stuck_en = '0;
    n = 0;
    while (n < 20 && bus.pause_ack !== 1'b0) begin
      step();
      n++;
    end
    chk("stuck_recover_ack", 8'(bus.pause_ack), 8'h00);
    chk("stuck_recover_req", 8'(bus.child_req), 8'h00);
    $display("stuck child released after %0d cycles", n);

    rand_lat(2);
    run_seq("pause_pre_reset", 1'b1, 0, 0);

    // Reset while waiting on child 2 during a resume.
    lat[0] = 0; lat[1] = 0; lat[2] = 6; lat[3] = 0;
    run_seq("resume_aborted", 1'b0, 5, 0);
    rst_n = 1'b0;
    bus.pause_req = 1'b1;
    #1;
    chk("midreset_req", 8'(bus.child_req), 8'h0f);
    chk("midreset_ack", 8'(bus.pause_ack), 8'h01);
    repeat (5) step();
    rst_n = 1'b1;
    chk_hold("after_midreset", 3, 4'b1111, 1'b1);
    $display("reset during resume aborted the sequence");

    rand_lat(4);
    run_seq("fresh_resume", 1'b0, 0, 0);
    rand_lat(4);
    run_seq("final_pause", 1'b1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
